// File: rtl/column_cfg_pkg.sv
// Shared definitions for the column configuration loader: FSM state
// encoding, the header sync byte, and a width helper.
package column_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam int         SYNC_W   = 8;
    localparam logic [7:0] CFG_SYNC = 8'hA5;

    // $clog2 that never returns zero, so 1-deep counters still get a bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a frame index plus enable into a registered one-hot FrameStrobe.
// Out-of-range indices decode to all-zero, so the column never sees a
// strobe on a line that does not exist.
module frame_strobe_decoder
    import column_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int IW              = clog2_min1(MaxFramesPerCol)
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic [IW-1:0]              idx,
    input  logic                       en,
    output logic [MaxFramesPerCol-1:0] strobe
);

    logic [MaxFramesPerCol-1:0] strobe_d;

    // Decode: at most one line matches, none when idx is out of range
    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (en && (idx == IW'(i)))
                strobe_d[i] = 1'b1;
        end
    end

    // Register the strobe; reset drops it immediately
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn)
            strobe <= '0;
        else
            strobe <= strobe_d;
    end

endmodule

// File: rtl/column_frame_loader.sv
// Configuration sequencer for one fabric column. Collects a header plus
// NumRows data words over valid/ready, then holds FrameData steady while a
// single FrameStrobe line pulses for StrobeCycles cycles, followed by a
// one-cycle quiet gap before the next header is accepted.
module column_frame_loader
    import column_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [FrameBitsPerRow-1:0]         s_data,
    input  logic                               err_clr,
    output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic [15:0]                        frames_done,
    output logic                               err_addr,
    output logic                               err_sync
);

    localparam int FBR = FrameBitsPerRow;
    localparam int IW  = clog2_min1(MaxFramesPerCol);
    localparam int RW  = clog2_min1(NumRows);
    localparam int CW  = clog2_min1(StrobeCycles + 1);

    localparam logic [IW:0]   MAX_IDX  = (IW+1)'(MaxFramesPerCol);
    localparam logic [RW-1:0] LAST_ROW = RW'(NumRows - 1);
    localparam logic [CW-1:0] SC_END   = CW'(StrobeCycles);

    state_t                     state;
    logic [RW-1:0]              row;
    logic [CW-1:0]              scnt;
    logic [IW-1:0]              idx_q;
    logic [NumRows-1:0][FBR-1:0] data_q;
    logic [15:0]                frames_q;
    logic                       err_addr_q;
    logic                       err_sync_q;

    logic          xfer;
    logic          is_sync;
    logic [IW-1:0] hdr_idx;
    logic          idx_ok;
    logic          last_row;
    logic          strobe_last;
    logic          strobe_en;

    assign s_ready     = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DRAIN);
    assign busy        = (state != ST_IDLE);
    assign xfer        = s_valid & s_ready;
    assign is_sync     = (s_data[FBR-1 -: SYNC_W] == CFG_SYNC);
    assign hdr_idx     = s_data[IW-1:0];
    assign idx_ok      = ({1'b0, hdr_idx} < MAX_IDX);
    assign last_row    = (row == LAST_ROW);
    assign strobe_last = (scnt == SC_END);
    // The strobe register lags the state by one edge, so STROBE lasts one
    // extra cycle (scnt == StrobeCycles) in which the decoder is disabled.
    assign strobe_en   = (state == ST_STROBE) && (scnt < SC_END);

    // Sequencer: header decode, row counting, strobe timing
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            row   <= '0;
            scnt  <= '0;
            idx_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer && is_sync) begin
                        row <= '0;
                        if (idx_ok) begin
                            idx_q <= hdr_idx;
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        if (last_row) begin
                            row   <= '0;
                            scnt  <= '0;
                            state <= ST_STROBE;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        if (last_row) begin
                            row   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                ST_STROBE: begin
                    scnt <= scnt + CW'(1);
                    if (strobe_last)
                        state <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Row registers only change while loading, so they are stable in STROBE/GAP
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn)
            data_q <= '0;
        else if ((state == ST_LOAD) && xfer)
            data_q[row] <= s_data;
    end

    // Frame counter bumps on entry to GAP; wraps naturally at 16 bits
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn)
            frames_q <= '0;
        else if ((state == ST_STROBE) && strobe_last)
            frames_q <= frames_q + 16'd1;
    end

    // Sticky error flags; a new error in the same cycle beats err_clr
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            err_addr_q <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && xfer && is_sync && !idx_ok)
                err_addr_q <= 1'b1;
            else if (err_clr)
                err_addr_q <= 1'b0;

            if ((state == ST_IDLE) && xfer && !is_sync)
                err_sync_q <= 1'b1;
            else if (err_clr)
                err_sync_q <= 1'b0;
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .IW              (IW)
    ) u_strobe (
        .UserCLK (UserCLK),
        .resetn  (resetn),
        .idx     (idx_q),
        .en      (strobe_en),
        .strobe  (FrameStrobe)
    );

    assign FrameData   = data_q;
    assign frames_done = frames_q;
    assign err_addr    = err_addr_q;
    assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_column_frame_loader.sv
// Directed bench for column_frame_loader: frame load/strobe timing, last
// index with stalling source, bad index drain, sync errors and err_clr,
// reset during strobe, frame counter wrap with continuous valid.
module tb_column_frame_loader;

    localparam int MF  = 20;
    localparam int FBR = 32;
    localparam int NR  = 4;
    localparam int SC  = 2;

    logic              UserCLK = 1'b0;
    logic              resetn  = 1'b0;
    logic              s_valid = 1'b0;
    logic              err_clr = 1'b0;
    logic [FBR-1:0]    s_data  = '0;
    logic              s_ready;
    logic [FBR*NR-1:0] FrameData;
    logic [MF-1:0]     FrameStrobe;
    logic              busy;
    logic [15:0]       frames_done;
    logic              err_addr;
    logic              err_sync;

    int nchecks = 0;
    int nerrors = 0;

    column_frame_loader #(
        .MaxFramesPerCol (MF),
        .FrameBitsPerRow (FBR),
        .NumRows         (NR),
        .StrobeCycles    (SC)
    ) dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .err_clr     (err_clr),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .frames_done (frames_done),
        .err_addr    (err_addr),
        .err_sync    (err_sync)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word transfer; gap idle cycles with s_valid low first.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [FBR-1:0] d, input int gap);
        int w;
        repeat (gap) @(negedge UserCLK);
        @(negedge UserCLK);
        s_valid = 1'b1;
        s_data  = d;
        w = 0;
        while (!s_ready && w < 20) begin
            @(negedge UserCLK);
            w++;
        end
        if (!s_ready) chk("send_ready_timeout", {127'd0, s_ready}, 128'd1);
        @(posedge UserCLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [FBR-1:0] hdr, input logic [FBR-1:0] r0,
                              input logic [FBR-1:0] r1, input logic [FBR-1:0] r2,
                              input logic [FBR-1:0] r3, input int gap);
        send(hdr, gap);
        send(r0, gap);
        send(r1, gap);
        send(r2, gap);
        send(r3, gap);
    endtask

    // Called right after the last row's accepting edge N
    task automatic strobe_seq(input string tg, input logic [MF-1:0] oh,
                              input logic [15:0] done_exp, input logic [127:0] fd);
        @(negedge UserCLK);
        chk({tg, "_strobe_n0"}, 128'(FrameStrobe), 128'd0);
        chk({tg, "_ready_n0"}, 128'(s_ready), 128'd0);
        chk({tg, "_busy_n0"}, 128'(busy), 128'd1);
        chk({tg, "_data_n0"}, FrameData, fd);
        @(negedge UserCLK);
        chk({tg, "_strobe_n1"}, 128'(FrameStrobe), 128'(oh));
        chk({tg, "_data_n1"}, FrameData, fd);
        @(negedge UserCLK);
        chk({tg, "_strobe_n2"}, 128'(FrameStrobe), 128'(oh));
        chk({tg, "_data_n2"}, FrameData, fd);
        @(negedge UserCLK);
        chk({tg, "_strobe_n3"}, 128'(FrameStrobe), 128'd0);
        chk({tg, "_ready_n3"}, 128'(s_ready), 128'd0);
        chk({tg, "_done_n3"}, 128'(frames_done), 128'(done_exp));
        @(negedge UserCLK);
        chk({tg, "_ready_n4"}, 128'(s_ready), 128'd1);
        chk({tg, "_busy_n4"}, 128'(busy), 128'd0);
    endtask

    logic [FBR-1:0] wv [10];
    int k;

    initial begin
        // ---- reset state
        #12;
        chk("rst_strobe", 128'(FrameStrobe), 128'd0);
        chk("rst_data", FrameData, 128'd0);
        chk("rst_ready", 128'(s_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(frames_done), 128'd0);
        chk("rst_errs", 128'({err_addr, err_sync}), 128'd0);
        resetn = 1'b1;

        // ---- basic frame, idx 3
        send(32'hA500_0003, 0);
        chk("t1_busy_load", 128'(busy), 128'd1);
        send(32'h1111_1111, 0);
        send(32'h2222_2222, 0);
        send(32'h3333_3333, 0);
        send(32'h4444_4444, 0);
        strobe_seq("t1", 20'h0_0008, 16'd1,
                   128'h4444_4444_3333_3333_2222_2222_1111_1111);

        // ---- idx 19, valid toggling every other cycle
        send_frame(32'hA500_0013, 32'hA0A0_A0A0, 32'hB1B1_B1B1,
                   32'hC2C2_C2C2, 32'hD3D3_D3D3, 1);
        strobe_seq("t2", 20'h8_0000, 16'd2,
                   128'hD3D3_D3D3_C2C2_C2C2_B1B1_B1B1_A0A0_A0A0);

        // ---- idx 20: drain four words, nothing strobed
        send(32'hA500_0014, 0);
        chk("t3_err_addr", 128'(err_addr), 128'd1);
        chk("t3_busy_drain", 128'(busy), 128'd1);
        for (int i = 0; i < NR; i++) begin
            send(32'hDEAD_BEE0 + 32'(i), 0);
            chk($sformatf("t3_strobe_w%0d", i), 128'(FrameStrobe), 128'd0);
        end
        @(negedge UserCLK);
        chk("t3_busy_after", 128'(busy), 128'd0);
        chk("t3_strobe_after", 128'(FrameStrobe), 128'd0);
        chk("t3_done_same", 128'(frames_done), 128'd2);
        chk("t3_data_same", FrameData, 128'hD3D3_D3D3_C2C2_C2C2_B1B1_B1B1_A0A0_A0A0);
        send_frame(32'hA500_0000, 32'h0000_0001, 32'h0000_0002,
                   32'h0000_0003, 32'h0000_0004, 0);
        strobe_seq("t3b", 20'h0_0001, 16'd3,
                   128'h0000_0004_0000_0003_0000_0002_0000_0001);

        // ---- sync errors and err_clr
        send(32'h1234_5678, 0);
        chk("t4_err_sync", 128'(err_sync), 128'd1);
        chk("t4_ready", 128'(s_ready), 128'd1);
        chk("t4_busy", 128'(busy), 128'd0);
        @(negedge UserCLK);
        err_clr = 1'b1;
        @(posedge UserCLK);
        #1;
        err_clr = 1'b0;
        chk("t4_clr_sync", 128'(err_sync), 128'd0);
        chk("t4_clr_addr", 128'(err_addr), 128'd0);
        err_clr = 1'b1;
        send(32'h1234_5678, 0);
        err_clr = 1'b0;
        chk("t4_err_wins", 128'(err_sync), 128'd1);
        chk("t4_done_same", 128'(frames_done), 128'd3);

        // ---- reset asserted during STROBE
        send_frame(32'hA500_0005, 32'h5555_0000, 32'h5555_0001,
                   32'h5555_0002, 32'h5555_0003, 0);
        @(negedge UserCLK);
        @(negedge UserCLK);
        chk("t5_strobe_pre", 128'(FrameStrobe), 128'h20);
        #1 resetn = 1'b0;
        #1;
        chk("t5_strobe_rst", 128'(FrameStrobe), 128'd0);
        chk("t5_busy_rst", 128'(busy), 128'd0);
        chk("t5_done_rst", 128'(frames_done), 128'd0);
        chk("t5_ready_rst", 128'(s_ready), 128'd1);
        chk("t5_errs_rst", 128'({err_addr, err_sync}), 128'd0);
        #1 resetn = 1'b1;
        send_frame(32'hA500_0002, 32'h6666_0000, 32'h6666_0001,
                   32'h6666_0002, 32'h6666_0003, 0);
        strobe_seq("t5b", 20'h0_0004, 16'd1,
                   128'h6666_0003_6666_0002_6666_0001_6666_0000);

        // ---- frame counter wrap, s_valid held high across two frames
        @(negedge UserCLK);
        force dut.frames_q = 16'hFFFF;
        #1;
        release dut.frames_q;
        wv[0] = 32'hA500_0007; wv[1] = 32'h7000_0000; wv[2] = 32'h7000_0001;
        wv[3] = 32'h7000_0002; wv[4] = 32'h7000_0003;
        wv[5] = 32'hA500_0007; wv[6] = 32'h7100_0000; wv[7] = 32'h7100_0001;
        wv[8] = 32'h7100_0002; wv[9] = 32'h7100_0003;
        k = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge UserCLK);
            s_valid = (k < 10);
            s_data  = (k < 10) ? wv[k] : '0;
            chk($sformatf("t6_ready_c%0d", c), 128'(s_ready), 128'((c % 9) < 5));
            chk($sformatf("t6_strobe_c%0d", c), 128'(FrameStrobe),
                ((c % 9) == 6 || (c % 9) == 7) ? 128'h80 : 128'd0);
            if (c == 8)  chk("t6_wrap", 128'(frames_done), 128'h0000);
            if (c == 17) chk("t6_after_wrap", 128'(frames_done), 128'h0001);
            if (s_ready && s_valid) k++;
        end
        @(negedge UserCLK);
        s_valid = 1'b0;
        chk("t6_words_taken", 128'(k), 128'd10);
        chk("t6_data", FrameData, 128'h7100_0003_7100_0002_7100_0001_7100_0000);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
